dr_sweep_controller: RTL

Sequencer for the FIR dynamic-range test path. It steps the sine-generator amplitude through a linear sweep and waits a settling interval at each level. It then measures the FIR output's max, min and peak-to-peak over a fixed sample window, and hands one result record per level to a downstream logger through a valid/ready handshake. It sits between the stimulus generators (sine + LFSR noise) and the fir_filter output, replacing open-loop delay-based sweeping.

---
 rtl/dr_sweep_if.sv | 40 ++++
 rtl/dr_sweep_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dr_sweep_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : dr_sweep_if
// Desc   : Sweep control, FIR sample and result-record signals of the sweeper.
// Rev    : 1.0  initial release
// ============================================================================
interface dr_sweep_if #(
  parameter int OUT_WIDTH = 32,
  parameter int AMP_WIDTH = 16
);
  logic                        start;
  logic                        abort;
  logic signed [OUT_WIDTH-1:0] fir_data;
  logic                        fir_valid;
  logic [AMP_WIDTH-1:0]        amplitude;
  logic                        gen_enable;
  logic                        busy;
  logic                        done;
  logic                        res_valid;
  logic                        res_ready;
  logic [7:0]                  res_step;
  logic [AMP_WIDTH-1:0]        res_amp;
  logic signed [OUT_WIDTH-1:0] res_max;
  logic signed [OUT_WIDTH-1:0] res_min;
  logic [OUT_WIDTH:0]          res_p2p;

  modport master (
    input  start, abort, fir_data, fir_valid, res_ready,
    output amplitude, gen_enable, busy, done,
           res_valid, res_step, res_amp, res_max, res_min, res_p2p
  );

  modport slave (
    output start, abort, fir_data, fir_valid, res_ready,
    input  amplitude, gen_enable, busy, done,
           res_valid, res_step, res_amp, res_max, res_min, res_p2p
  );
endinterface
`default_nettype wire

// File: rtl/dr_sweep_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : dr_sweep_controller
// Desc   : Amplitude sweep sequencer measuring FIR max/min/peak-to-peak per level.
// Rev    : 1.0  initial release
// ============================================================================
module dr_sweep_controller #(
  parameter int OUT_WIDTH       = 32,
  parameter int AMP_WIDTH       = 16,
  parameter int STEPS           = 10,
  parameter int AMP_MAX         = 65535,
  parameter int SETTLE_CYCLES   = 480,
  parameter int MEASURE_SAMPLES = 1024
) (
  input  wire logic   clk,
  input  wire logic   rst,
  dr_sweep_if.master  bus
);

  localparam int c_AMP_STEP = AMP_MAX / STEPS;
  localparam int c_SET_W    = $clog2(SETTLE_CYCLES + 1);
  localparam int c_MEAS_W   = $clog2(MEASURE_SAMPLES + 1);

  localparam logic [c_SET_W-1:0]          c_SETTLE_LAST = c_SET_W'(SETTLE_CYCLES - 1);
  localparam logic [c_MEAS_W-1:0]         c_MEAS_LAST   = c_MEAS_W'(MEASURE_SAMPLES - 1);
  localparam logic [7:0]                  c_STEP_LAST   = 8'(STEPS - 1);
  localparam logic signed [OUT_WIDTH-1:0] c_MOST_NEG    = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] c_MOST_POS    = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_REPORT  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                      r_state;
  logic [7:0]                  r_step;
  logic [c_SET_W-1:0]          r_settle_cnt;
  logic [c_MEAS_W-1:0]         r_sample_cnt;
  logic signed [OUT_WIDTH-1:0] r_max;
  logic signed [OUT_WIDTH-1:0] r_min;

  logic signed [OUT_WIDTH-1:0] w_new_max;
  logic signed [OUT_WIDTH-1:0] w_new_min;
  logic [AMP_WIDTH-1:0]        w_next_amp;

  // Running extrema including the sample on the bus this cycle
  assign w_new_max  = (bus.fir_data > r_max) ? bus.fir_data : r_max;
  assign w_new_min  = (bus.fir_data < r_min) ? bus.fir_data : r_min;
  assign w_next_amp = AMP_WIDTH'((int'(r_step) + 1) * c_AMP_STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_step         <= '0;
      r_settle_cnt   <= '0;
      r_sample_cnt   <= '0;
      r_max          <= '0;
      r_min          <= '0;
      bus.amplitude  <= '0;
      bus.gen_enable <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res_step   <= '0;
      bus.res_amp    <= '0;
      bus.res_max    <= '0;
      bus.res_min    <= '0;
      bus.res_p2p    <= '0;
    end else if (bus.abort && (r_state != S_IDLE)) begin
      r_state        <= S_IDLE;
      r_step         <= '0;
      r_settle_cnt   <= '0;
      r_sample_cnt   <= '0;
      bus.amplitude  <= '0;
      bus.gen_enable <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.res_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start && !bus.abort) begin
            r_state        <= S_SETTLE;
            r_step         <= '0;
            r_settle_cnt   <= '0;
            bus.amplitude  <= '0;
            bus.gen_enable <= 1'b1;
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == c_SETTLE_LAST) begin
            r_state      <= S_MEASURE;
            r_sample_cnt <= '0;
            r_max        <= c_MOST_NEG;
            r_min        <= c_MOST_POS;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_MEASURE: begin
          if (bus.fir_valid) begin
            r_max <= w_new_max;
            r_min <= w_new_min;
            if (r_sample_cnt == c_MEAS_LAST) begin
              r_state        <= S_REPORT;
              bus.gen_enable <= 1'b0;
              bus.res_valid  <= 1'b1;
              bus.res_step   <= r_step;
              bus.res_amp    <= bus.amplitude;
              bus.res_max    <= w_new_max;
              bus.res_min    <= w_new_min;
              // One extra bit keeps full-scale swings from wrapping negative
              bus.res_p2p    <= {w_new_max[OUT_WIDTH-1], w_new_max}
                              - {w_new_min[OUT_WIDTH-1], w_new_min};
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (r_step == c_STEP_LAST) begin
              r_state       <= S_DONE;
              bus.amplitude <= '0;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
            end else begin
              r_state        <= S_SETTLE;
              r_step         <= r_step + 1'b1;
              r_settle_cnt   <= '0;
              bus.amplitude  <= w_next_amp;
              bus.gen_enable <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
